// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter.
//   rx_state_t      : receiver FSM states
//   UART_OVERSAMPLE : default clock ticks per bit
//   UART_DATA_BITS  : default data bits per frame
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial pin plus falling-edge detect.
// All flops reset to 1 (idle line level), so reset never fakes a start edge.
//   clock : sampling clock
//   reset : asynchronous, active-high
//   rx    : raw serial pin
//   rx_s  : synchronized line level
//   fall  : rx_s went 1 -> 0 this cycle (combinational from flops)
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  // Synchronizer chain and one-cycle delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver running on the oversampling baud clock.
// Deserializes frames LSB first; good frames update the byte output and pulse
// valid, frames whose stop bit samples low pulse frameError instead.
//   clock            : oversampling clock (OVERSAMPLE ticks per bit)
//   reset            : asynchronous, active-high
//   io_rx            : serial line, idle high, asynchronous to clock
//   io_dataOut_bits  : last correctly framed byte, held between valid pulses
//   io_dataOut_valid : one-cycle pulse per good frame
//   io_frameError    : one-cycle pulse when the stop bit samples low
//   io_busy          : high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_rx,
  output logic [DATA_BITS-1:0] io_dataOut_bits,
  output logic                 io_dataOut_valid,
  output logic                 io_frameError,
  output logic                 io_busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  rx_state_t            state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [IW-1:0]        idx, idx_d;
  logic [DATA_BITS-1:0] sh, sh_d;
  logic [DATA_BITS-1:0] bits_d;
  logic                 valid_d;
  logic                 ferr_d;
  logic                 busy_d;

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .rx    (io_rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      idx              <= '0;
      sh               <= '0;
      io_dataOut_bits  <= '0;
      io_dataOut_valid <= 1'b0;
      io_frameError    <= 1'b0;
      io_busy          <= 1'b0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      idx              <= idx_d;
      sh               <= sh_d;
      io_dataOut_bits  <= bits_d;
      io_dataOut_valid <= valid_d;
      io_frameError    <= ferr_d;
      io_busy          <= busy_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = sh;
    bits_d  = io_dataOut_bits;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state)
      IDLE: begin
        // Edge-triggered, so a line held low (break) cannot restart a frame.
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        // Re-check the line half a bit in to reject glitches.
        if (cnt == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          sh_d  = {rx_s, sh[DATA_BITS-1:1]};
          cnt_d = '0;
          idx_d = idx + IW'(1);
          if (idx == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rx_s) begin
            bits_d  = sh;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the stimulus pushes each expected frame result,
// a negedge monitor pops and checks whenever valid or frameError pulses.
module tb_uart_rx;

  logic       clock;
  logic       reset;
  logic       io_rx;
  logic [7:0] io_dataOut_bits;
  logic       io_dataOut_valid;
  logic       io_frameError;
  logic       io_busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     cyc;    // 0 = arrival cycle not checked
  } exp_t;

  exp_t   q[$];
  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;

  uart_rx dut (
    .clock            (clock),
    .reset            (reset),
    .io_rx            (io_rx),
    .io_dataOut_bits  (io_dataOut_bits),
    .io_dataOut_valid (io_dataOut_valid),
    .io_frameError    (io_frameError),
    .io_busy          (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_err, input logic [7:0] data, input longint c);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.cyc    = c;
    q.push_back(e);
  endtask

  // Drives one frame from the current time; returns the cycle count at the start edge.
  task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_v,
                            output longint c_drop);
    io_rx  = 1'b0;
    c_drop = cyc;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      #(bit_t);
    end
    io_rx = stop_v;
    #(bit_t);
  endtask

  task automatic idle_bits(input int n);
    io_rx = 1'b1;
    repeat (n * 16) @(negedge clock);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && (io_dataOut_valid || io_frameError)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b bits=0x%02h (cycle %0d)",
                 io_dataOut_valid, io_frameError, io_dataOut_bits, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", 32'({io_dataOut_valid, io_frameError}),
            e.is_err ? 32'd1 : 32'd2);
        chk("dataOut_bits", 32'(io_dataOut_bits), 32'(e.data));
        if (e.cyc != 0) chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    longint c;
    io_rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_bits",  32'(io_dataOut_bits), 32'h00);
    chk("reset_valid", 32'(io_dataOut_valid), 32'd0);
    chk("reset_ferr",  32'(io_frameError), 32'd0);
    chk("reset_busy",  32'(io_busy), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Good frame at exact rate; valid lands 155 cycles after the pin edge cycle.
    push(1'b0, 8'hA5, 0);
    q[q.size()-1].cyc = cyc + 155;
    send_frame(8'hA5, 160, 1'b1, c);
    idle_bits(2);

    // Back-to-back frames, single stop bit each.
    push(1'b0, 8'h00, 0);
    push(1'b0, 8'hFF, 0);
    push(1'b0, 8'h3C, 0);
    send_frame(8'h00, 160, 1'b1, c);
    send_frame(8'hFF, 160, 1'b1, c);
    send_frame(8'h3C, 160, 1'b1, c);
    idle_bits(2);

    // Glitch: 4 ticks low is rejected at the mid-start check.
    io_rx = 1'b0;
    c = cyc;
    @(negedge clock);
    @(negedge clock);
    chk("glitch_busy_pre", 32'(io_busy), 32'd0);
    @(negedge clock);
    chk("glitch_busy_set", 32'(io_busy), 32'd1);
    @(negedge clock);
    io_rx = 1'b1;
    while (cyc != c + 10) @(negedge clock);
    chk("glitch_busy_mid", 32'(io_busy), 32'd1);
    @(negedge clock);
    chk("glitch_busy_drop", 32'(io_busy), 32'd0);
    idle_bits(2);
    push(1'b0, 8'h5A, 0);
    send_frame(8'h5A, 160, 1'b1, c);
    idle_bits(2);

    // Stop bit low: frame error, byte output keeps 0x5A; then a long break.
    push(1'b1, 8'h5A, 0);
    send_frame(8'h81, 160, 1'b0, c);
    repeat (20 * 16) @(negedge clock);
    chk("break_busy", 32'(io_busy), 32'd0);
    chk("break_bits", 32'(io_dataOut_bits), 32'h5A);
    repeat (20 * 16) @(negedge clock);
    chk("break_end_busy", 32'(io_busy), 32'd0);
    idle_bits(2);
    push(1'b0, 8'h42, 0);
    send_frame(8'h42, 160, 1'b1, c);
    idle_bits(2);

    // Asynchronous reset in the middle of data bit 3 of an aborted frame.
    @(negedge clock);
    io_rx = 1'b0;
    #160;
    for (int i = 0; i < 3; i++) begin
      io_rx = (i == 1) ? 1'b1 : 1'b0;
      #160;
    end
    io_rx = 1'b0;
    #82;
    reset = 1'b1;
    #1;
    chk("arst_bits",  32'(io_dataOut_bits), 32'h00);
    chk("arst_valid", 32'(io_dataOut_valid), 32'd0);
    chk("arst_ferr",  32'(io_frameError), 32'd0);
    chk("arst_busy",  32'(io_busy), 32'd0);
    io_rx = 1'b1;
    #20;
    reset = 1'b0;
    @(negedge clock);
    idle_bits(3);
    push(1'b0, 8'hC3, 0);
    send_frame(8'hC3, 160, 1'b1, c);
    idle_bits(2);

    // Baud mismatch: slow transmitter (17 ticks/bit) and fast one (15.6 ticks/bit).
    push(1'b0, 8'h96, 0);
    send_frame(8'h96, 170, 1'b1, c);
    idle_bits(2);
    @(negedge clock);
    push(1'b0, 8'h96, 0);
    send_frame(8'h96, 156, 1'b1, c);
    idle_bits(2);

    // Every expected pulse must have arrived.
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clock);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
